registrador_banco_multiporta: RTL and testbench
===============================================

# registrador_banco_multiporta

Parametrised register bank for the single-cycle/pipelined MIPS datapath: one synchronous write port, `NUM_RD` registered read ports and a per-register pending (scoreboard) bit used by the control unit to detect reads of registers whose value is still in flight. It sits between instruction decode (read addresses) and write-back (write port). It replaces the unclocked bank, which had no reset, no zero register and no hazard tracking.

## Interface
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, address width; depth = 2^ADDR_W
- `NUM_RD`, 2, number of read ports (≥1)
- `ZERO_REG`, 1, 1 = register 0 reads as 0, ignores writes and is never pending
- `RESET_VAL`, 0, value loaded into every register on reset
- `clock` in 1: single clock, all state updates on rising edge
- `reset` in 1: synchronous, active-high
- `we` in 1: write enable
- `wr_addr` in ADDR_W: destination register
- `wr_data` in DATA_W: write-back data
- `rd_addr` in NUM_RD*ADDR_W: read addresses; port k = bits [k*ADDR_W +: ADDR_W]
- `rd_data` out NUM_RD*DATA_W: registered read data, same packing
- `rd_pend` out NUM_RD: registered pending flag for each read port
- `pend_set` in 1: mark `pend_addr` as pending (instruction issued with that destination)
- `pend_addr` in ADDR_W: register to mark
- `pend_any` out 1: OR of all pending bits (combinational from state)

## Operation
- Storage `mem[0..2^ADDR_W-1]`, pending vector `pend[0..2^ADDR_W-1]`.
- Write: on edge with `we`=1, `mem[wr_addr]<=wr_data` and `pend[wr_addr]<=0`; skipped for address 0 when `ZERO_REG`=1.
- Pend set: on edge with `pend_set`=1, `pend[pend_addr]<=1` (never for address 0 when `ZERO_REG`=1).
- Same-edge set and clear on the same address: set wins (a new producer overrides the completing one).
- Read port k: on every edge, `rd_data[k]<=mem[rd_addr[k]]`, `rd_pend[k]<=pend[rd_addr[k]]`; address 0 with `ZERO_REG`=1 gives data 0, pend 0.
- Read-during-write collision: governed by `REG_BYPASS_EN` (see Configuration).
- Multiple read ports may address the same register; each returns the same value.

## Timing
- Read latency: 1 cycle (address at edge N, data valid after edge N until edge N+1).
- Write visible to a non-colliding read issued at the next edge.
- Reset (any cycle, including during a write or pend_set): all `mem`=RESET_VAL, all `pend`=0, `rd_data`=0, `rd_pend`=0, `pend_any`=0 after the edge; concurrent write/set is dropped.
- `pend_any` reflects state after the last edge, no input path.

## Configuration
- `REG_BYPASS_EN` defined: read port with `we`=1 and `rd_addr[k]==wr_addr` (nonzero or `ZERO_REG`=0) captures `wr_data` and `rd_pend[k]`=0 unless `pend_set` targets the same address that edge (then 1).
- Not defined: read-before-write; the port captures the old `mem` value and the old `pend` bit; new value visible one cycle later.

## Structure
- Shared package `registrador_pkg`: default `DATA_W`/`ADDR_W`, `REG_ZERO` address constant, register-address typedef `reg_addr_t`.
- One sub-module `porta_leitura`: a single read port (mux, zero-reg masking, bypass compare, output registers), instantiated `NUM_RD` times via generate.

## Test plan
- Reset then read r1, r31 -> `rd_data`=RESET_VAL each, `rd_pend`=0, `pend_any`=0.
- Write r5=0xDEADBEEF, next cycle read port 0 r5 -> 0xDEADBEEF after one edge; write r0=0x1234 then read r0 -> 0.
- Same-edge write r7=0xA5A5A5A5 and read r7 (old 0x4) -> 0xA5A5A5A5 with `REG_BYPASS_EN`, 0x4 without; following read 0xA5A5A5A5 in both.
- `pend_set` r9, read r9 on both ports -> `rd_pend`=2'b11, `pend_any`=1; write r9 -> next read `rd_pend`=0, `pend_any`=0.
- Same edge `pend_set` r3 and write r3 -> `pend[3]`=1, data updated.
- Assert `reset` on same edge as write r2=0xFF and `pend_set` r2 -> r2 reads RESET_VAL, `rd_pend`=0.

Source files
------------

// File: rtl/registrador_banco_multiporta_pkg.sv
// registrador_pkg: shared defaults and types for the MIPS register bank.
// Optional bypass build macro: REG_BYPASS_EN.
package registrador_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/registrador_banco_multiporta_if.sv
// Bus bundle between decode/write-back and the register bank.
// Optional bypass build macro: REG_BYPASS_EN.
interface registrador_banco_multiporta_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);

  logic                     we;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pend;
  logic                     pend_set;
  logic [ADDR_W-1:0]        pend_addr;
  logic                     pend_any;

  modport master (
    output we, wr_addr, wr_data,
    output rd_addr, pend_set, pend_addr,
    input  rd_data, rd_pend, pend_any
  );

  modport slave (
    input  we, wr_addr, wr_data,
    input  rd_addr, pend_set, pend_addr,
    output rd_data, rd_pend, pend_any
  );

endinterface

// File: rtl/registrador_banco_multiporta_porta_leitura.sv
// porta_leitura: one registered read port with zero masking.
// Build macro REG_BYPASS_EN forwards same-edge write data to the port.
module porta_leitura
  import registrador_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1,
  localparam int DEPTH   = 1 << ADDR_W
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [ADDR_W-1:0]            i_rd_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0] i_mem,
  input  logic [DEPTH-1:0]             i_pend,
`ifdef REG_BYPASS_EN
  input  logic                         i_we,
  input  logic [ADDR_W-1:0]            i_wr_addr,
  input  logic [DATA_W-1:0]            i_wr_data,
  input  logic                         i_pend_set,
  input  logic [ADDR_W-1:0]            i_pend_addr,
`endif
  output logic [DATA_W-1:0]            o_rd_data,
  output logic                         o_rd_pend
);

  logic              w_zero;
  logic [DATA_W-1:0] w_data;
  logic              w_pend;

  // select the source for this port: bank, bypass or hardwired zero
  always_comb begin
    w_zero = ZERO_REG && (i_rd_addr == '0);
    w_data = i_mem[i_rd_addr];
    w_pend = i_pend[i_rd_addr];
`ifdef REG_BYPASS_EN
    if (i_we && (i_rd_addr == i_wr_addr)) begin
      w_data = i_wr_data;
      w_pend = i_pend_set && (i_pend_addr == i_rd_addr);
    end
`endif
    if (w_zero) begin
      w_data = '0;
      w_pend = 1'b0;
    end
  end

  // output registers give the one-cycle read latency
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rd_data <= '0;
      o_rd_pend <= 1'b0;
    end else begin
      o_rd_data <= w_data;
      o_rd_pend <= w_pend;
    end
  end

endmodule

// File: rtl/registrador_banco_multiporta.sv
// Register bank with one write port, NUM_RD read ports, pending bits.
// Build macro REG_BYPASS_EN selects write-to-read forwarding.
module registrador_banco_multiporta
  import registrador_pkg::*;
#(
  parameter int              DATA_W    = DATA_W_DEF,
  parameter int              ADDR_W    = ADDR_W_DEF,
  parameter int              NUM_RD    = 2,
  parameter bit              ZERO_REG  = 1'b1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input logic                         clock,
  input logic                         reset,
  registrador_banco_multiporta_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] r_mem;
  logic [DEPTH-1:0]             r_pend;

  logic                         w_wr_ok;
  logic                         w_set_ok;
  logic [DATA_W-1:0]            w_rd_data [NUM_RD];
  logic                         w_rd_pend [NUM_RD];

  // register 0 is read-only and never pending when ZERO_REG is set
  always_comb begin
    w_wr_ok  = bus.we &&
               !(ZERO_REG && (bus.wr_addr == ADDR_W'(REG_ZERO)));
    w_set_ok = bus.pend_set &&
               !(ZERO_REG && (bus.pend_addr == ADDR_W'(REG_ZERO)));
  end

  // storage and scoreboard; a new producer beats the completing write
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset) begin
        r_mem[i]  <= RESET_VAL;
        r_pend[i] <= 1'b0;
      end else begin
        if (w_wr_ok && (bus.wr_addr == ADDR_W'(i))) begin
          r_mem[i]  <= bus.wr_data;
          r_pend[i] <= 1'b0;
        end
        if (w_set_ok && (bus.pend_addr == ADDR_W'(i))) begin
          r_pend[i] <= 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    porta_leitura #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_porta (
      .i_clk       (clock),
      .i_rst       (reset),
      .i_rd_addr   (bus.rd_addr[k*ADDR_W +: ADDR_W]),
      .i_mem       (r_mem),
      .i_pend      (r_pend),
`ifdef REG_BYPASS_EN
      .i_we        (w_wr_ok),
      .i_wr_addr   (bus.wr_addr),
      .i_wr_data   (bus.wr_data),
      .i_pend_set  (w_set_ok),
      .i_pend_addr (bus.pend_addr),
`endif
      .o_rd_data   (w_rd_data[k]),
      .o_rd_pend   (w_rd_pend[k])
    );
  end

  // pack the per-port registers onto the bus
  always_comb begin
    bus.rd_data = '0;
    bus.rd_pend = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      bus.rd_data[k*DATA_W +: DATA_W] = w_rd_data[k];
      bus.rd_pend[k]                  = w_rd_pend[k];
    end
  end

  // summary of in-flight destinations, straight from state
  always_comb begin
    bus.pend_any = |r_pend;
  end

endmodule

// File: tb/tb_registrador_banco_multiporta.sv
// Bench for registrador_banco_multiporta (2 ports, ZERO_REG=1).
// Honors REG_BYPASS_EN in its reference model.
module tb_registrador_banco_multiporta;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  registrador_banco_multiporta_if #(
    .DATA_W (32),
    .ADDR_W (5),
    .NUM_RD (2)
  ) bus ();

  registrador_banco_multiporta #(
    .DATA_W    (32),
    .ADDR_W    (5),
    .NUM_RD    (2),
    .ZERO_REG  (1'b1),
    .RESET_VAL (32'h0)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] d;
    logic        p;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_mem [32];
  logic        m_pend [32];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic r,
                     input logic w,
                     input logic [4:0] wa,
                     input logic [31:0] wd,
                     input logic ps,
                     input logic [4:0] pa,
                     input logic [4:0] a0,
                     input logic [4:0] a1,
                     input string tag);
    logic [4:0] ad [2];
    exp_t       e;
    logic       any;
    ad[0] = a0;
    ad[1] = a1;
    rst          = r;
    bus.we       = w;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    bus.pend_set = ps;
    bus.pend_addr = pa;
    bus.rd_addr  = {a1, a0};
    for (int k = 0; k < 2; k++) begin
      e.tag = $sformatf("%s.p%0d", tag, k);
      e.d   = m_mem[ad[k]];
      e.p   = m_pend[ad[k]];
`ifdef REG_BYPASS_EN
      if (w && ad[k] == wa) begin
        e.d = wd;
        e.p = ps && (pa == ad[k]);
      end
`endif
      if (r || ad[k] == 5'd0) begin
        e.d = 32'h0;
        e.p = 1'b0;
      end
      q.push_back(e);
    end
    if (r) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  = 32'h0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (w && wa != 5'd0) begin
        m_mem[wa]  = wd;
        m_pend[wa] = 1'b0;
      end
      if (ps && pa != 5'd0) m_pend[pa] = 1'b1;
    end
    any = 1'b0;
    for (int i = 0; i < 32; i++) any |= m_pend[i];
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      e = q.pop_front();
      check({e.tag, ".d"}, bus.rd_data[k*32 +: 32], e.d);
      check({e.tag, ".pd"}, 32'(bus.rd_pend[k]), 32'(e.p));
    end
    check({tag, ".any"}, 32'(bus.pend_any), 32'(any));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = 32'h0;
      m_pend[i] = 1'b0;
    end
    bus.we = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.pend_set = 1'b0;
    bus.pend_addr = '0;
    bus.rd_addr = '0;
    #2;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "rst");
    cyc(0, 0, 0, 0, 0, 0, 1, 31, "rd_r1_r31");
    cyc(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, "wr_r5");
    cyc(0, 0, 0, 0, 0, 0, 5, 5, "rd_r5");
    cyc(0, 1, 0, 32'h1234, 0, 0, 0, 0, "wr_r0");
    cyc(0, 0, 0, 0, 0, 0, 0, 5, "rd_r0");
    cyc(0, 1, 7, 32'h4, 0, 0, 0, 0, "wr_r7_old");
    cyc(0, 1, 7, 32'hA5A5A5A5, 0, 0, 7, 7, "coll_r7");
    cyc(0, 0, 0, 0, 0, 0, 7, 7, "rd_r7");
    cyc(0, 0, 0, 0, 1, 9, 0, 0, "set_r9");
    cyc(0, 0, 0, 0, 0, 0, 9, 9, "rd_r9_pend");
    cyc(0, 1, 9, 32'h99, 0, 0, 0, 0, "wr_r9");
    cyc(0, 0, 0, 0, 0, 0, 9, 9, "rd_r9_clr");
    cyc(0, 1, 3, 32'h33, 1, 3, 0, 0, "set_wr_r3");
    cyc(0, 0, 0, 0, 0, 0, 3, 3, "rd_r3");
    cyc(0, 1, 3, 32'h34, 0, 0, 0, 0, "wr_r3");
    cyc(0, 0, 0, 0, 1, 0, 0, 0, "set_r0");
    cyc(0, 1, 2, 32'h11, 0, 0, 0, 0, "wr_r2");
    cyc(1, 1, 2, 32'hFF, 1, 2, 2, 2, "rst_wr_r2");
    cyc(0, 0, 0, 0, 0, 0, 2, 2, "rd_r2");
    for (int n = 0; n < 300; n++) begin
      cyc($urandom_range(0, 49) == 0,
          1'($urandom_range(0, 1)),
          5'($urandom_range(0, 7)),
          $urandom,
          1'($urandom_range(0, 1)),
          5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)),
          "rnd");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
